// File: rtl/dp_arbiter_if.sv
// dp_arbiter_if: requester, result and datapath-controller signals of dp_arbiter.
interface dp_arbiter_if #(parameter int DW = 16);
  logic [1:0]    req;
  logic [DW-1:0] x0;
  logic [DW-1:0] x1;
  logic [1:0]    grant;
  logic [1:0]    done;
  logic [DW-1:0] result;
  logic          err;
  logic          busy;
  logic          dp_clr;
  logic          dp_start;
  logic [DW-1:0] dp_x;
  logic          dp_finished;
  logic [DW-1:0] dp_result;
  modport master (
    output req, x0, x1, dp_finished, dp_result,
    input  grant, done, result, err, busy, dp_clr, dp_start, dp_x
  );
  modport slave (
    input  req, x0, x1, dp_finished, dp_result,
    output grant, done, result, err, busy, dp_clr, dp_start, dp_x
  );
endinterface

// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin two-requester arbiter sequencing jobs on a shared datapath.
// Optional watchdog on the WAIT state enabled by defining DP_WATCHDOG_EN.
module dp_arbiter #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 32
) (
  input logic         clk,
  input logic         RST,
  dp_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, DONE} state_t;
  state_t state;
  logic   ptr;
  logic   win;
  logic   timeout;
  if (TIMEOUT < 2) $error("TIMEOUT must be at least 2");
  assign win          = &bus.req ? ptr : bus.req[1];
  assign bus.busy     = state != IDLE;
  assign bus.dp_clr   = state == CLEAR;
  assign bus.dp_start = state == LAUNCH;
  assign bus.done     = state == DONE ? bus.grant : 2'b00;
  always_ff @(posedge clk)
    if (!RST) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      bus.grant  <= 2'b00;
      bus.result <= {DW{1'b0}};
      bus.dp_x   <= {DW{1'b0}};
    end else
      case (state)
        IDLE: if (|bus.req) begin
          bus.grant <= win ? 2'b10 : 2'b01;
          bus.dp_x  <= win ? bus.x1 : bus.x0;
          state     <= CLEAR;
        end
        CLEAR:  state <= LAUNCH;
        LAUNCH: state <= WAIT;
        WAIT: if (bus.dp_finished) begin
          bus.result <= bus.dp_result;
          state      <= DONE;
        end else if (timeout) begin
          bus.result <= {DW{1'b0}};
          state      <= DONE;
        end
        default: begin
          // hand preference to whoever did not own the job just finished
          ptr       <= ~bus.grant[1];
          bus.grant <= 2'b00;
          state     <= IDLE;
        end
      endcase
`ifdef DP_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  assign timeout = cnt == LAST;
  always_ff @(posedge clk)
    if (!RST) begin
      cnt     <= '0;
      bus.err <= 1'b0;
    end else begin
      cnt     <= state == WAIT && !bus.dp_finished ? cnt + 1'b1 : '0;
      bus.err <= state == WAIT && !bus.dp_finished && timeout;
    end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: scenario tasks plus randomized jobs checked against a transaction-level model.
module tb_dp_arbiter;
  localparam int DW = 16, TIMEOUT = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cmp = 0;
  int   bad = 0;
  logic ptr = 1'b0;
  always #5 clk = ~clk;
  dp_arbiter_if #(.DW(DW)) bus();
  dp_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .RST(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus.req = 2'b00;
    tick;
    rst = 1'b1;
    ptr = 1'b0;
  endtask

  // One full job: request in IDLE, lat WAIT cycles before finished rises, done, then one IDLE cycle.
  task automatic job(input logic [1:0] r, input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] res, input int lat, input bit churn, input bit rel, input string tag);
    logic w;
    logic [1:0] g;
    logic [15:0] ex;
    w  = (r == 2'b11) ? ptr : r[1];
    g  = w ? 2'b10 : 2'b01;
    ex = w ? a1 : a0;
    bus.req = r; bus.x0 = a0; bus.x1 = a1;
    tick;
    cmp++;
    if ({bus.grant, bus.dp_clr, bus.dp_start, bus.busy, bus.done, bus.dp_x} !== {g, 1'b1, 1'b0, 1'b1, 2'b00, ex}) begin
      bad++;
      $display("FAIL %s clear: grant=%b clr=%b start=%b busy=%b done=%b dp_x=%h, want grant=%b clr=1 start=0 busy=1 done=00 dp_x=%h",
               tag, bus.grant, bus.dp_clr, bus.dp_start, bus.busy, bus.done, bus.dp_x, g, ex);
    end
    if (churn) begin bus.req = 2'($urandom); bus.x0 = 16'($urandom); bus.x1 = 16'($urandom); end
    tick;
    cmp++;
    if ({bus.grant, bus.dp_clr, bus.dp_start, bus.done, bus.dp_x} !== {g, 1'b0, 1'b1, 2'b00, ex}) begin
      bad++;
      $display("FAIL %s launch: grant=%b clr=%b start=%b done=%b dp_x=%h, want grant=%b clr=0 start=1 done=00 dp_x=%h",
               tag, bus.grant, bus.dp_clr, bus.dp_start, bus.done, bus.dp_x, g, ex);
    end
    if (churn) bus.req = 2'($urandom);
    tick;
    bus.dp_finished = 1'b0;
    for (int i = 0; i < lat; i++) begin
      cmp++;
      if ({bus.grant, bus.dp_clr, bus.dp_start, bus.busy, bus.done, bus.dp_x} !== {g, 1'b0, 1'b0, 1'b1, 2'b00, ex}) begin
        bad++;
        $display("FAIL %s wait%0d: grant=%b clr=%b start=%b busy=%b done=%b dp_x=%h, want grant=%b clr=0 start=0 busy=1 done=00 dp_x=%h",
                 tag, i, bus.grant, bus.dp_clr, bus.dp_start, bus.busy, bus.done, bus.dp_x, g, ex);
      end
      if (churn) bus.req = 2'($urandom);
      tick;
    end
    bus.dp_finished = 1'b1;
    bus.dp_result = res;
    tick;
    cmp++;
    if ({bus.done, bus.result, bus.err, bus.grant, bus.busy, bus.dp_x} !== {g, res, 1'b0, g, 1'b1, ex}) begin
      bad++;
      $display("FAIL %s done: done=%b result=%h err=%b grant=%b busy=%b dp_x=%h, want done=%b result=%h err=0 grant=%b busy=1 dp_x=%h",
               tag, bus.done, bus.result, bus.err, bus.grant, bus.busy, bus.dp_x, g, res, g, ex);
    end
    if (rel) bus.req = 2'b00;
    tick;
    cmp++;
    if ({bus.grant, bus.done, bus.busy, bus.err, bus.dp_clr, bus.result} !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, res}) begin
      bad++;
      $display("FAIL %s idle: grant=%b done=%b busy=%b err=%b clr=%b result=%h, want 00 00 0 0 0 result=%h",
               tag, bus.grant, bus.done, bus.busy, bus.err, bus.dp_clr, bus.result, res);
    end
    ptr = ~w;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    cmp++;
    if ({bus.grant, bus.done, bus.err, bus.busy, bus.dp_clr, bus.dp_start, bus.result, bus.dp_x} !== '0) begin
      bad++;
      $display("FAIL reset: grant=%b done=%b err=%b busy=%b clr=%b start=%b result=%h dp_x=%h, want all zero",
               bus.grant, bus.done, bus.err, bus.busy, bus.dp_clr, bus.dp_start, bus.result, bus.dp_x);
    end
    rst = 1'b1;
    ptr = 1'b0;
    tick;
    cmp++;
    if ({bus.busy, bus.grant} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: busy=%b grant=%b, want 0 00", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single;
    job(2'b01, 16'h0005, 16'h7777, 16'h0031, 5, 1'b0, 1'b1, "single");
  endtask

  task automatic test_sticky;
    bus.dp_finished = 1'b1;
    bus.dp_result = 16'hdead;
    for (int i = 0; i < 3; i++) begin
      tick;
      cmp++;
      if ({bus.busy, bus.done} !== 3'b000) begin
        bad++;
        $display("FAIL sticky_idle%0d: busy=%b done=%b, want 0 00", i, bus.busy, bus.done);
      end
    end
    job(2'b10, 16'h1111, 16'h2222, 16'h4321, 3, 1'b0, 1'b1, "sticky");
  endtask

  task automatic test_back_to_back;
    logic [1:0] want [3] = '{2'b01, 2'b10, 2'b01};
    do_reset;
    for (int j = 0; j < 3; j++) begin
      cmp++;
      if (((ptr ? 2'b10 : 2'b01)) !== want[j]) begin
        bad++;
        $display("FAIL b2b_order%0d: model grant=%b, want %b", j, ptr ? 2'b10 : 2'b01, want[j]);
      end
      job(2'b11, 16'(100 + j), 16'(200 + j), 16'($urandom), 1, 1'b0, 1'b0, $sformatf("b2b%0d", j));
    end
    bus.req = 2'b00;
    tick;
  endtask

  task automatic test_reset_midjob;
    job(2'b01, 16'h0abc, 16'h0def, 16'h5a5a, 0, 1'b0, 1'b1, "pre_rst");
    bus.req = 2'b11;
    tick;
    tick;
    tick;
    tick;
    rst = 1'b0;
    bus.dp_finished = 1'b1;
    tick;
    cmp++;
    if ({bus.grant, bus.done, bus.err, bus.busy, bus.dp_clr, bus.dp_start, bus.result, bus.dp_x} !== '0) begin
      bad++;
      $display("FAIL rst_mid: grant=%b done=%b err=%b busy=%b clr=%b start=%b result=%h dp_x=%h, want all zero",
               bus.grant, bus.done, bus.err, bus.busy, bus.dp_clr, bus.dp_start, bus.result, bus.dp_x);
    end
    rst = 1'b1;
    ptr = 1'b0;
    bus.req = 2'b00;
    tick;
    cmp++;
    if ({bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_idle: busy=%b done=%b, want 0 00", bus.busy, bus.done);
    end
    job(2'b11, 16'h0101, 16'h0202, 16'h0303, 2, 1'b0, 1'b1, "post_rst_ptr");
    job(2'b10, 16'h0404, 16'h0505, 16'h0606, 2, 1'b0, 1'b1, "post_rst_r1");
  endtask

  task automatic test_watchdog;
    bus.req = 2'b01;
    bus.x0 = 16'h00aa;
    tick;
    tick;
    tick;
    bus.dp_finished = 1'b0;
    bus.req = 2'b00;
`ifdef DP_WATCHDOG_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      cmp++;
      if ({bus.busy, bus.done, bus.err} !== 4'b1000) begin
        bad++;
        $display("FAIL wd_wait%0d: busy=%b done=%b err=%b, want 1 00 0", i, bus.busy, bus.done, bus.err);
      end
      tick;
    end
    cmp++;
    if ({bus.done, bus.err, bus.result} !== {2'b01, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL wd_done: done=%b err=%b result=%h, want 01 1 0000", bus.done, bus.err, bus.result);
    end
    tick;
    cmp++;
    if ({bus.busy, bus.err, bus.done} !== 4'b0000) begin
      bad++;
      $display("FAIL wd_idle: busy=%b err=%b done=%b, want 0 0 00", bus.busy, bus.err, bus.done);
    end
    ptr = 1'b1;
`else
    for (int i = 0; i < 200; i++) begin
      cmp++;
      if ({bus.busy, bus.done, bus.err} !== 4'b1000) begin
        bad++;
        $display("FAIL nowd_wait%0d: busy=%b done=%b err=%b, want 1 00 0", i, bus.busy, bus.done, bus.err);
      end
      tick;
    end
    do_reset;
    tick;
`endif
  endtask

  task automatic test_random;
    for (int j = 0; j < 40; j++) begin
      job(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", j));
      if ($urandom_range(0, 2) == 0) begin
        bus.req = 2'b00;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          tick;
          cmp++;
          if ({bus.busy, bus.grant, bus.done} !== 5'b00000) begin
            bad++;
            $display("FAIL rnd%0d_gap: busy=%b grant=%b done=%b, want 0 00 00", j, bus.busy, bus.grant, bus.done);
          end
        end
      end
    end
  endtask

  initial begin
    bus.req = 2'b00;
    bus.x0 = '0;
    bus.x1 = '0;
    bus.dp_finished = 1'b0;
    bus.dp_result = '0;
    test_reset;
    test_single;
    test_sticky;
    test_back_to_back;
    test_reset_midjob;
    test_watchdog;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
